// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for the byte-wide memory arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic              ifetch_memarb_en_in;
    logic [ADDR_W-1:0] ifetch_memarb_addr_in;
    logic              memarb_ifetch_en_out;
    logic [XLEN-1:0]   memarb_ifetch_data_out;

    logic              lbuffer_memarb_en_in;
    logic [ADDR_W-1:0] lbuffer_memarb_addr_in;
    logic [2:0]        lbuffer_memarb_width_in;
    logic              lbuffer_memarb_sgn_in;
    logic              memarb_lbuffer_en_out;
    logic [XLEN-1:0]   memarb_lbuffer_data_out;

    logic              sbuffer_memarb_en_in;
    logic [ADDR_W-1:0] sbuffer_memarb_addr_in;
    logic [2:0]        sbuffer_memarb_width_in;
    logic [XLEN-1:0]   sbuffer_memarb_data_in;
    logic              memarb_sbuffer_en_out;

    logic [7:0]        mem_din_in;
    logic [7:0]        mem_dout_out;
    logic [ADDR_W-1:0] mem_a_out;
    logic              mem_wr_out;

    modport slave (
        input  ifetch_memarb_en_in, ifetch_memarb_addr_in,
        output memarb_ifetch_en_out, memarb_ifetch_data_out,
        input  lbuffer_memarb_en_in, lbuffer_memarb_addr_in,
        input  lbuffer_memarb_width_in, lbuffer_memarb_sgn_in,
        output memarb_lbuffer_en_out, memarb_lbuffer_data_out,
        input  sbuffer_memarb_en_in, sbuffer_memarb_addr_in,
        input  sbuffer_memarb_width_in, sbuffer_memarb_data_in,
        output memarb_sbuffer_en_out,
        input  mem_din_in,
        output mem_dout_out, mem_a_out, mem_wr_out
    );

    modport master (
        output ifetch_memarb_en_in, ifetch_memarb_addr_in,
        input  memarb_ifetch_en_out, memarb_ifetch_data_out,
        output lbuffer_memarb_en_in, lbuffer_memarb_addr_in,
        output lbuffer_memarb_width_in, lbuffer_memarb_sgn_in,
        input  memarb_lbuffer_en_out, memarb_lbuffer_data_out,
        output sbuffer_memarb_en_in, sbuffer_memarb_addr_in,
        output sbuffer_memarb_width_in, sbuffer_memarb_data_in,
        input  memarb_sbuffer_en_out,
        output mem_din_in,
        input  mem_dout_out, mem_a_out, mem_wr_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port owner: serialises fetch, load and store accesses
// into per-byte RAM cycles and extends load results.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         rdy_in,
    input  logic         rob_memarb_rst_in,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d, cnt_inc;
    logic [2:0]        nb_q;
    logic [ADDR_W-1:0] base_q;
    logic              sgn_q;
    logic              src_lb_q;
    logic [XLEN-1:0]   wdata_q;
    logic [31:0]       rbuf_q;
    logic              rr_lb_q;

    logic              if_pend_q, lb_pend_q, sb_pend_q;
    logic [ADDR_W-1:0] if_addr_q, lb_addr_q, sb_addr_q;
    logic [2:0]        lb_w_q, sb_w_q;
    logic              lb_sgn_q;
    logic [XLEN-1:0]   sb_data_q;

    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;
    logic              if_done_q, lb_done_q, sb_done_q;
    logic [XLEN-1:0]   if_data_q, lb_data_q;

    logic              stall_q;
    logic [7:0]        din_hold_q;

    logic              g_sb, g_lb, g_if, g_any;
    logic              rd_fin, wr_fin, flush;
    logic [ADDR_W-1:0] g_addr, nxt_a;
    logic [2:0]        g_nb;
    logic              g_sgn;
    logic [XLEN-1:0]   g_data, wshift, rd_val;
    logic [7:0]        din_sel;
    logic [1:0]        cap_idx;
    logic [31:0]       cap_word;

    function automatic logic [2:0] nbytes(input logic [2:0] w);
        unique case (w)
            3'b001:  return 3'd1;
            3'b010:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extend(
        input logic [31:0] v,
        input logic [2:0]  n,
        input logic        sgn
    );
        logic [XLEN-1:0] r;
        unique case (n)
            3'd1: begin
                r = {XLEN{sgn & v[7]}};
                r[7:0] = v[7:0];
            end
            3'd2: begin
                r = {XLEN{sgn & v[15]}};
                r[15:0] = v[15:0];
            end
            default: begin
                r = {XLEN{sgn & v[31]}};
                r[31:0] = v;
            end
        endcase
        return r;
    endfunction

    assign flush   = rob_memarb_rst_in;
    assign cnt_inc = cnt_q + 3'd1;
    assign nxt_a   = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
    assign wshift  = wdata_q >> {cnt_inc, 3'b000};
    assign g_any   = g_sb | g_lb | g_if;

    // After a stall the RAM has moved on to the held address, so the
    // byte that was on mem_din_in when the stall began is replayed.
    assign din_sel = stall_q ? din_hold_q : bus.mem_din_in;
    assign cap_idx = cnt_q[1:0] - 2'd1;

    always_comb begin
        cap_word = rbuf_q;
        cap_word[{cap_idx, 3'b000} +: 8] = din_sel;
    end

    assign rd_val = extend(cap_word, nb_q, sgn_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_sb    = 1'b0;
        g_lb    = 1'b0;
        g_if    = 1'b0;
        rd_fin  = 1'b0;
        wr_fin  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sb_pend_q) begin
                    g_sb    = 1'b1;
                    state_d = WR;
                    cnt_d   = '0;
                end else if (!flush) begin
                    if (lb_pend_q && (rr_lb_q || !if_pend_q)) begin
                        g_lb    = 1'b1;
                        state_d = RD;
                        cnt_d   = '0;
                    end else if (if_pend_q) begin
                        g_if    = 1'b1;
                        state_d = RD;
                        cnt_d   = '0;
                    end
                end
            end
            RD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == nb_q) begin
                    rd_fin  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WR: begin
                if (cnt_inc == nb_q) begin
                    wr_fin  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        g_addr = if_addr_q;
        g_nb   = 3'd4;
        g_sgn  = 1'b0;
        g_data = '0;
        unique case (1'b1)
            g_sb: begin
                g_addr = sb_addr_q;
                g_nb   = nbytes(sb_w_q);
                g_data = sb_data_q;
            end
            g_lb: begin
                g_addr = lb_addr_q;
                g_nb   = nbytes(lb_w_q);
                g_sgn  = lb_sgn_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_q    <= 1'b0;
            din_hold_q <= '0;
        end else begin
            stall_q <= ~rdy_in;
            if (!rdy_in && !stall_q) din_hold_q <= bus.mem_din_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nb_q       <= '0;
            base_q     <= '0;
            sgn_q      <= 1'b0;
            src_lb_q   <= 1'b0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            rr_lb_q    <= 1'b1;
            if_pend_q  <= 1'b0;
            lb_pend_q  <= 1'b0;
            sb_pend_q  <= 1'b0;
            if_addr_q  <= '0;
            lb_addr_q  <= '0;
            sb_addr_q  <= '0;
            lb_w_q     <= '0;
            sb_w_q     <= '0;
            lb_sgn_q   <= 1'b0;
            sb_data_q  <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            lb_done_q  <= 1'b0;
            sb_done_q  <= 1'b0;
            if_data_q  <= '0;
            lb_data_q  <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            if_done_q <= 1'b0;
            lb_done_q <= 1'b0;
            sb_done_q <= 1'b0;

            if (flush) begin
                if_pend_q <= 1'b0;
            end else if (bus.ifetch_memarb_en_in) begin
                if_pend_q <= 1'b1;
                if_addr_q <= bus.ifetch_memarb_addr_in;
            end else if (g_if) begin
                if_pend_q <= 1'b0;
            end

            if (flush) begin
                lb_pend_q <= 1'b0;
            end else if (bus.lbuffer_memarb_en_in) begin
                lb_pend_q <= 1'b1;
                lb_addr_q <= bus.lbuffer_memarb_addr_in;
                lb_w_q    <= bus.lbuffer_memarb_width_in;
                lb_sgn_q  <= bus.lbuffer_memarb_sgn_in;
            end else if (g_lb) begin
                lb_pend_q <= 1'b0;
            end

            if (bus.sbuffer_memarb_en_in) begin
                sb_pend_q <= 1'b1;
                sb_addr_q <= bus.sbuffer_memarb_addr_in;
                sb_w_q    <= bus.sbuffer_memarb_width_in;
                sb_data_q <= bus.sbuffer_memarb_data_in;
            end else if (g_sb) begin
                sb_pend_q <= 1'b0;
            end

            if (g_any) begin
                base_q     <= g_addr;
                nb_q       <= g_nb;
                sgn_q      <= g_sgn;
                wdata_q    <= g_data;
                src_lb_q   <= g_lb;
                rbuf_q     <= '0;
                mem_a_q    <= g_addr;
                mem_dout_q <= g_data[7:0];
                mem_wr_q   <= g_sb;
            end
            if (g_lb || g_if) rr_lb_q <= ~rr_lb_q;

            if (state_q == RD && !flush) begin
                if (cnt_q != '0) rbuf_q <= cap_word;
                if (cnt_inc < nb_q) mem_a_q <= nxt_a;
            end

            if (rd_fin) begin
                if (src_lb_q) begin
                    lb_done_q <= 1'b1;
                    lb_data_q <= rd_val;
                end else begin
                    if_done_q <= 1'b1;
                    if_data_q <= rd_val;
                end
            end

            if (state_q == WR) begin
                if (wr_fin) begin
                    mem_wr_q  <= 1'b0;
                    sb_done_q <= 1'b1;
                end else begin
                    mem_a_q    <= nxt_a;
                    mem_dout_q <= wshift[7:0];
                end
            end
        end
    end

    assign bus.mem_a_out               = mem_a_q;
    assign bus.mem_dout_out            = mem_dout_q;
    assign bus.mem_wr_out              = mem_wr_q & rdy_in;
    assign bus.memarb_ifetch_en_out    = if_done_q;
    assign bus.memarb_ifetch_data_out  = if_data_q;
    assign bus.memarb_lbuffer_en_out   = lb_done_q;
    assign bus.memarb_lbuffer_data_out = lb_data_q;
    assign bus.memarb_sbuffer_en_out   = sb_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte RAM model answers the
// arbiter, expected done events are queued in grant order.
module tb_mem_arbiter;

    localparam int SRC_IF = 0;
    localparam int SRC_LB = 1;
    localparam int SRC_SB = 2;

    typedef struct {
        int          src;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic flush;

    logic [7:0]  ram [0:1023];
    logic [7:0]  ram_q;
    logic        poke_en;
    logic [9:0]  poke_a;
    logic [7:0]  poke_d;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mem_arbiter_if #(.ADDR_W(32), .XLEN(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .XLEN(32)) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .rdy_in            (rdy),
        .rob_memarb_rst_in (flush),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (poke_en) ram[poke_a] <= poke_d;
        else if (bus.mem_wr_out) ram[bus.mem_a_out[9:0]] <= bus.mem_dout_out;
        ram_q <= ram[bus.mem_a_out[9:0]];
    end
    assign bus.mem_din_in = ram_q;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic push(input int src, input logic [31:0] d);
        exp_t e;
        e.src = src;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic got(input int src, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done: got src %0d data %h, required none",
                     src, d);
        end else begin
            e = exp_q.pop_front();
            chk("done_src", 32'(src), 32'(e.src));
            chk("done_data", d, e.data);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && rdy) begin
                if (bus.memarb_sbuffer_en_out) got(SRC_SB, 32'h0);
                if (bus.memarb_lbuffer_en_out)
                    got(SRC_LB, bus.memarb_lbuffer_data_out);
                if (bus.memarb_ifetch_en_out)
                    got(SRC_IF, bus.memarb_ifetch_data_out);
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL %s_timeout: got %0d pending, required 0",
                     tag, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic req_if(input logic [31:0] a);
        bus.ifetch_memarb_en_in   = 1'b1;
        bus.ifetch_memarb_addr_in = a;
    endtask

    task automatic req_lb(input logic [31:0] a, input logic [2:0] w,
                          input logic s);
        bus.lbuffer_memarb_en_in    = 1'b1;
        bus.lbuffer_memarb_addr_in  = a;
        bus.lbuffer_memarb_width_in = w;
        bus.lbuffer_memarb_sgn_in   = s;
    endtask

    task automatic req_sb(input logic [31:0] a, input logic [2:0] w,
                          input logic [31:0] d);
        bus.sbuffer_memarb_en_in    = 1'b1;
        bus.sbuffer_memarb_addr_in  = a;
        bus.sbuffer_memarb_width_in = w;
        bus.sbuffer_memarb_data_in  = d;
    endtask

    task automatic clr_req();
        bus.ifetch_memarb_en_in  = 1'b0;
        bus.lbuffer_memarb_en_in = 1'b0;
        bus.sbuffer_memarb_en_in = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] w,
                        input logic s, input logic [31:0] exp);
        push(SRC_LB, exp);
        req_lb(a, w, s);
        tick();
        clr_req();
        drain("load");
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        push(SRC_IF, exp);
        req_if(a);
        tick();
        clr_req();
        drain("fetch");
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] w,
                         input logic [31:0] d);
        push(SRC_SB, 32'h0);
        req_sb(a, w, d);
        tick();
        clr_req();
        drain("store");
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        flush = 1'b0;
        poke_en = 1'b0;
        poke_a  = '0;
        poke_d  = '0;
        clr_req();
        bus.ifetch_memarb_addr_in   = '0;
        bus.lbuffer_memarb_addr_in  = '0;
        bus.lbuffer_memarb_width_in = '0;
        bus.lbuffer_memarb_sgn_in   = 1'b0;
        bus.sbuffer_memarb_addr_in  = '0;
        bus.sbuffer_memarb_width_in = '0;
        bus.sbuffer_memarb_data_in  = '0;

        for (int i = 0; i < 1024; i++) poke(10'(i), 8'h00);
        poke(10'h100, 8'h78);
        poke(10'h101, 8'h56);
        poke(10'h102, 8'h34);
        poke(10'h103, 8'h12);
        poke(10'h110, 8'h80);
        poke(10'h120, 8'h80);
        poke(10'h121, 8'hFF);
        poke(10'h122, 8'h80);
        poke(10'h123, 8'hFF);

        chk("rst_mem_a", bus.mem_a_out, 32'h0);
        chk("rst_mem_dout", 32'(bus.mem_dout_out), 32'h0);
        chk("rst_mem_wr", 32'(bus.mem_wr_out), 32'h0);
        chk("rst_if_done", 32'(bus.memarb_ifetch_en_out), 32'h0);
        chk("rst_lb_done", 32'(bus.memarb_lbuffer_en_out), 32'h0);
        chk("rst_sb_done", 32'(bus.memarb_sbuffer_en_out), 32'h0);
        chk("rst_if_data", bus.memarb_ifetch_data_out, 32'h0);
        chk("rst_lb_data", bus.memarb_lbuffer_data_out, 32'h0);

        rst_n = 1'b1;
        fork
            monitor();
        join_none
        tick();
        tick();

        // All three on one edge: store first, then lbuffer wins the tie.
        push(SRC_SB, 32'h0);
        push(SRC_LB, 32'h12345678);
        push(SRC_IF, 32'hFF80FF80);
        req_sb(32'h208, 3'b001, 32'h00000055);
        req_lb(32'h100, 3'b100, 1'b0);
        req_if(32'h120);
        tick();
        clr_req();
        drain("arb3");

        load(32'h110, 3'b001, 1'b1, 32'hFFFFFF80);

        // Last grant went to lbuffer, so a tie now favours ifetch.
        push(SRC_IF, 32'h12345678);
        push(SRC_LB, 32'h00000080);
        req_lb(32'h110, 3'b001, 1'b0);
        req_if(32'h100);
        tick();
        clr_req();
        drain("tie");

        // LW timing: addresses in cycles 1-4, done in cycle 6.
        push(SRC_LB, 32'h12345678);
        req_lb(32'h100, 3'b100, 1'b0);
        tick();
        clr_req();
        tick();
        chk("lw_a_c1", bus.mem_a_out, 32'h100);
        tick();
        chk("lw_a_c2", bus.mem_a_out, 32'h101);
        tick();
        chk("lw_a_c3", bus.mem_a_out, 32'h102);
        tick();
        chk("lw_a_c4", bus.mem_a_out, 32'h103);
        tick();
        chk("lw_done_c5", 32'(bus.memarb_lbuffer_en_out), 32'h0);
        tick();
        chk("lw_done_c6", 32'(bus.memarb_lbuffer_en_out), 32'h1);
        drain("lw");

        load(32'h110, 3'b001, 1'b0, 32'h00000080);
        load(32'h120, 3'b010, 1'b0, 32'h0000FF80);
        load(32'h120, 3'b010, 1'b1, 32'hFFFFFF80);
        fetch(32'h110, 32'h00000080);
        load(32'h208, 3'b001, 1'b1, 32'h00000055);

        // SH 0xABCD to 0x200.
        push(SRC_SB, 32'h0);
        req_sb(32'h200, 3'b010, 32'h0000ABCD);
        tick();
        clr_req();
        tick();
        chk("sh_wr_c1", 32'(bus.mem_wr_out), 32'h1);
        chk("sh_a_c1", bus.mem_a_out, 32'h200);
        chk("sh_d_c1", 32'(bus.mem_dout_out), 32'hCD);
        tick();
        chk("sh_wr_c2", 32'(bus.mem_wr_out), 32'h1);
        chk("sh_a_c2", bus.mem_a_out, 32'h201);
        chk("sh_d_c2", 32'(bus.mem_dout_out), 32'hAB);
        tick();
        chk("sh_wr_c3", 32'(bus.mem_wr_out), 32'h0);
        chk("sh_done_c3", 32'(bus.memarb_sbuffer_en_out), 32'h1);
        drain("sh");
        chk("sh_ram_200", 32'(ram[10'h200]), 32'hCD);
        load(32'h200, 3'b100, 1'b0, 32'h0000ABCD);

        store(32'h204, 3'b100, 32'h11223344);
        load(32'h204, 3'b100, 1'b0, 32'h11223344);

        // Flush during the second byte of a LW, then an immediate fetch.
        push(SRC_IF, 32'h12345678);
        req_lb(32'h100, 3'b100, 1'b0);
        tick();
        clr_req();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_if(32'h100);
        tick();
        clr_req();
        tick();
        chk("flush_refetch_a", bus.mem_a_out, 32'h100);
        tick();
        chk("flush_no_lb_done", 32'(bus.memarb_lbuffer_en_out), 32'h0);
        drain("flush_lw");

        // Flush during a SW: the store still completes.
        push(SRC_SB, 32'h0);
        req_sb(32'h210, 3'b100, 32'hDEADBEEF);
        tick();
        clr_req();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("flush_sw");
        load(32'h210, 3'b100, 1'b0, 32'hDEADBEEF);

        // Three-cycle stall in the middle of a LW.
        push(SRC_LB, 32'h12345678);
        req_lb(32'h100, 3'b100, 1'b0);
        tick();
        clr_req();
        tick();
        tick();
        rdy = 1'b0;
        tick();
        chk("stall_lw_a_hold", bus.mem_a_out, 32'h101);
        tick();
        tick();
        rdy = 1'b1;
        drain("stall_lw");

        // Three-cycle stall in the middle of a SW.
        push(SRC_SB, 32'h0);
        req_sb(32'h220, 3'b100, 32'hCAFEF00D);
        tick();
        clr_req();
        tick();
        chk("stall_sw_wr_before", 32'(bus.mem_wr_out), 32'h1);
        tick();
        rdy = 1'b0;
        #1;
        chk("stall_sw_wr_low", 32'(bus.mem_wr_out), 32'h0);
        tick();
        chk("stall_sw_a_hold", bus.mem_a_out, 32'h221);
        chk("stall_sw_wr_low2", 32'(bus.mem_wr_out), 32'h0);
        tick();
        tick();
        rdy = 1'b1;
        drain("stall_sw");
        load(32'h220, 3'b100, 1'b0, 32'hCAFEF00D);

        // Asynchronous reset in the middle of a SW: no done afterwards.
        req_sb(32'h230, 3'b100, 32'h01020304);
        tick();
        clr_req();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_mem_wr", 32'(bus.mem_wr_out), 32'h0);
        chk("arst_mem_a", bus.mem_a_out, 32'h0);
        chk("arst_mem_dout", 32'(bus.mem_dout_out), 32'h0);
        chk("arst_lb_data", bus.memarb_lbuffer_data_out, 32'h0);
        chk("arst_if_data", bus.memarb_ifetch_data_out, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("arst_wr_after", 32'(bus.mem_wr_out), 32'h0);

        load(32'h204, 3'b010, 1'b1, 32'h00003344);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
